tm_frame_sequencer: RTL and testbench

- Controller for the TM downlink bit switch: decides, bit by bit, whether the serial output carries attached sync marker (ASM) bits or encoded codeword bits.
- Generates the serial ASM bits plus the ASM-enable strobe, and a per-bit data request to the RS/codeword source. That source answers with its own bit-enable into the switch.
- Paced by a bit-rate strobe. Produces frames made of one ASM followed by one codeword block, with frame start/done pulses and a frame counter for housekeeping.

---
 rtl/tm_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_tm_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tm_frame_sequencer
// Controller for the TM downlink bit switch. Paced by a bit-rate strobe, it
// emits frames made of one attached sync marker (ASM) followed by one codeword
// block. For each ASM bit it drives the serial marker bit with a valid strobe;
// for each codeword bit it pulses a request to the codeword source, which
// answers with its own bit-enable into the switch.
//
// Ports
//   clk         system clock
//   Rst         asynchronous active-low reset
//   Enable      permits new frames to start
//   FrameReady  codeword source holds a complete frame
//   BitTick     one-clk strobe per output bit period (may be held high)
//   ASMOut      ASM bit to the switch (0 whenever En_ASM is 0)
//   En_ASM      ASM bit valid, one-clk pulse per ASM bit
//   DataReq     one-clk pulse requesting the next codeword bit
//   FrameStart  one-clk pulse together with the first ASM bit
//   FrameDone   one-clk pulse together with the last data request of a frame
//   Busy        high while the sequencer is not idle
//   FrameCount  completed frames, wraps 0xFFFF -> 0
//
// All outputs are registered and appear one clk after the BitTick that
// caused them.
// -----------------------------------------------------------------------------
module tm_frame_sequencer #(
   parameter logic [31:0] ASM_WORD   = 32'h1ACFFC1D,
   parameter int          ASM_LEN    = 32,
   parameter int          FRAME_BITS = 10200,
   parameter int          CNT_W      = 14
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        Enable,
   input  logic        FrameReady,
   input  logic        BitTick,
   output logic        ASMOut,
   output logic        En_ASM,
   output logic        DataReq,
   output logic        FrameStart,
   output logic        FrameDone,
   output logic        Busy,
   output logic [15:0] FrameCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ASM  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ASM_LAST  = CNT_W'(ASM_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [4:0]       ASM_TOP   = 5'(ASM_LEN - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_frame_cnt;
   logic             r_asm_out;
   logic             r_en_asm;
   logic             r_data_req;
   logic             r_frame_start;
   logic             r_frame_done;
   logic             r_busy;

   logic             w_start;
   logic [4:0]       w_asm_idx;
   logic             w_asm_bit;

   // A new frame may only start when both the enable and the source agree.
   assign w_start   = Enable & FrameReady;
   // Marker goes out MSB first: counter 0 selects bit ASM_LEN-1.
   assign w_asm_idx = ASM_TOP - r_cnt[4:0];
   assign w_asm_bit = ASM_WORD[w_asm_idx];

   // Sequencer FSM with registered bit strobes, busy flag and frame counter.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= CNT_ZERO;
         r_frame_cnt   <= 16'd0;
         r_asm_out     <= 1'b0;
         r_en_asm      <= 1'b0;
         r_data_req    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         // Pulses last exactly one clk; state and counter hold between ticks.
         r_asm_out     <= 1'b0;
         r_en_asm      <= 1'b0;
         r_data_req    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         if (BitTick) begin
            case (r_state)
               S_IDLE: begin
                  // The start tick itself carries no bit.
                  if (w_start) begin
                     r_state <= S_ASM;
                     r_cnt   <= CNT_ZERO;
                     r_busy  <= 1'b1;
                  end else begin
                     r_busy  <= 1'b0;
                  end
               end
               S_ASM: begin
                  r_asm_out     <= w_asm_bit;
                  r_en_asm      <= 1'b1;
                  r_frame_start <= (r_cnt == CNT_ZERO);
                  r_busy        <= 1'b1;
                  if (r_cnt == ASM_LAST) begin
                     r_state <= S_DATA;
                     r_cnt   <= CNT_ZERO;
                  end else begin
                     r_cnt   <= r_cnt + CNT_ONE;
                  end
               end
               S_DATA: begin
                  r_data_req <= 1'b1;
                  if (r_cnt == DATA_LAST) begin
                     r_frame_done <= 1'b1;
                     r_frame_cnt  <= r_frame_cnt + 16'd1;
                     r_cnt        <= CNT_ZERO;
                     // Inputs are re-sampled here so frames can abut.
                     if (w_start) begin
                        r_state <= S_ASM;
                        r_busy  <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_cnt  <= r_cnt + CNT_ONE;
                     r_busy <= 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end
            endcase
         end else begin
            r_busy <= r_busy;
         end
      end
   end

   assign ASMOut     = r_asm_out;
   assign En_ASM     = r_en_asm;
   assign DataReq    = r_data_req;
   assign FrameStart = r_frame_start;
   assign FrameDone  = r_frame_done;
   assign Busy       = r_busy;
   assign FrameCount = r_frame_cnt;

endmodule

// File: tb/tb_tm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tm_frame_sequencer
// Self-checking bench for tm_frame_sequencer (ASM_LEN=32, FRAME_BITS=16).
// A cycle model pushes the expected output record into a queue as each input
// cycle is driven; the record is popped and compared when the DUT output for
// that cycle is sampled on the following falling edge. A segment table plus
// hand-written sequences check pulse counts, marker content, frame counts,
// mid-frame abort and counter wrap.
// -----------------------------------------------------------------------------
module tb_tm_frame_sequencer;

   localparam int AL = 32;
   localparam int FB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic        tick;
   logic        asm_out;
   logic        en_asm;
   logic        data_req;
   logic        frame_start;
   logic        frame_done;
   logic        busy;
   logic [15:0] frame_count;

   tm_frame_sequencer #(
      .ASM_WORD   (32'h1ACFFC1D),
      .ASM_LEN    (AL),
      .FRAME_BITS (FB),
      .CNT_W      (6)
   ) dut (
      .clk        (clk),
      .Rst        (rst_n),
      .Enable     (en),
      .FrameReady (rdy),
      .BitTick    (tick),
      .ASMOut     (asm_out),
      .En_ASM     (en_asm),
      .DataReq    (data_req),
      .FrameStart (frame_start),
      .FrameDone  (frame_done),
      .Busy       (busy),
      .FrameCount (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        asm_bit;
      logic        en_asm;
      logic        req;
      logic        fs;
      logic        fd;
      logic        busy;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      logic        en;
      logic        rdy;
      int          period;
      int          clks;
      int          exp_asm;
      int          exp_req;
      int          exp_done;
      logic [15:0] exp_fc;
      logic        exp_busy;
   } seg_t;

   obs_t        sb_q[$];
   seg_t        segs[5];
   int          checks   = 0;
   int          failures = 0;

   // reference model state
   int          m_state;
   int          m_cnt;
   logic [15:0] m_fc;
   logic        m_busy;
   logic [31:0] asm_ref = 32'h1ACFFC1D;

   // observation counters
   int          n_asm, n_req, n_done, n_fs, cyc, first_fs_cyc;
   logic [31:0] asm_sr;

   function automatic obs_t cur();
      obs_t o;
      o.asm_bit = asm_out;
      o.en_asm  = en_asm;
      o.req     = data_req;
      o.fs      = frame_start;
      o.fd      = frame_done;
      o.busy    = busy;
      o.fc      = frame_count;
      return o;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_fc    = 16'd0;
      m_busy  = 1'b0;
      sb_q.delete();
   endtask

   task automatic clr_counts();
      n_asm        = 0;
      n_req        = 0;
      n_done       = 0;
      n_fs         = 0;
      cyc          = 0;
      first_fs_cyc = -1;
      asm_sr       = 32'd0;
   endtask

   // One clock: predict, push, clock, pop, compare, tally.
   task automatic step();
      obs_t e;
      obs_t o;
      obs_t x;
      e = '0;
      if (tick) begin
         case (m_state)
            0: begin
               if (en && rdy) begin
                  m_state = 1;
                  m_cnt   = 0;
               end
            end
            1: begin
               e.asm_bit = asm_ref[AL-1-m_cnt];
               e.en_asm  = 1'b1;
               e.fs      = (m_cnt == 0);
               if (m_cnt == AL-1) begin
                  m_state = 2;
                  m_cnt   = 0;
               end else begin
                  m_cnt++;
               end
            end
            default: begin
               e.req = 1'b1;
               if (m_cnt == FB-1) begin
                  e.fd    = 1'b1;
                  m_fc    = m_fc + 16'd1;
                  m_state = (en && rdy) ? 1 : 0;
                  m_cnt   = 0;
               end else begin
                  m_cnt++;
               end
            end
         endcase
      end
      e.busy = (m_state != 0);
      e.fc   = m_fc;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      o = cur();
      x = sb_q.pop_front();
      checks++;
      if (o !== x) begin
         failures++;
         $display("FAIL sb cyc=%0d act=%h exp=%h", cyc, o, x);
      end
      if (o.en_asm) begin
         n_asm++;
         asm_sr = {asm_sr[30:0], o.asm_bit};
      end
      if (o.req) n_req++;
      if (o.fd) n_done++;
      if (o.fs) begin
         n_fs++;
         if (first_fs_cyc < 0) first_fs_cyc = cyc;
      end
      cyc++;
   endtask

   // Single frame with Enable/FrameReady dropped at ASM bit 10.
   task automatic single_frame(input string tag, input logic [15:0] exp_fc);
      clr_counts();
      en   = 1'b1;
      rdy  = 1'b1;
      tick = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i == 11) begin
            en  = 1'b0;
            rdy = 1'b0;
         end
         step();
      end
      chk({tag, "_first_fs"}, first_fs_cyc, 1);
      chk({tag, "_n_fs"}, n_fs, 1);
      chk({tag, "_n_asm"}, n_asm, AL);
      chk({tag, "_n_req"}, n_req, FB);
      chk({tag, "_n_done"}, n_done, 1);
      chk({tag, "_asm_word"}, int'(asm_sr), int'(32'h1ACFFC1D));
      chk({tag, "_fc"}, int'(frame_count), int'(exp_fc));
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      segs[0] = '{1'b0, 1'b1, 1,  10,  0,  0, 0, 16'd1, 1'b0};
      segs[1] = '{1'b1, 1'b1, 1, 145, 96, 48, 3, 16'd4, 1'b1};
      segs[2] = '{1'b0, 1'b0, 1,  48, 32, 16, 1, 16'd5, 1'b0};
      segs[3] = '{1'b1, 1'b1, 4, 193, 32, 16, 1, 16'd6, 1'b1};
      segs[4] = '{1'b0, 1'b1, 4, 192, 32, 16, 1, 16'd7, 1'b0};

      en    = 1'b0;
      rdy   = 1'b0;
      tick  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      clr_counts();
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'(cur()), 0);
      rst_n = 1'b1;

      // First frame from reset.
      single_frame("frame1", 16'd1);

      // Segment table: back-to-back frames, slow ticks, idle.
      for (int s = 0; s < 5; s++) begin
         clr_counts();
         en  = segs[s].en;
         rdy = segs[s].rdy;
         for (int i = 0; i < segs[s].clks; i++) begin
            tick = ((i % segs[s].period) == 0);
            step();
         end
         chk($sformatf("seg%0d_n_asm", s), n_asm, segs[s].exp_asm);
         chk($sformatf("seg%0d_n_req", s), n_req, segs[s].exp_req);
         chk($sformatf("seg%0d_n_done", s), n_done, segs[s].exp_done);
         chk($sformatf("seg%0d_fc", s), int'(frame_count), int'(segs[s].exp_fc));
         chk($sformatf("seg%0d_busy", s), int'(busy), int'(segs[s].exp_busy));
      end

      // Reset asserted at DATA bit 7 aborts the frame immediately.
      clr_counts();
      en   = 1'b1;
      rdy  = 1'b1;
      tick = 1'b1;
      for (int i = 0; i < 1 + AL + 8; i++) step();
      chk("pre_abort_n_req", n_req, 8);
      chk("pre_abort_n_done", n_done, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", int'(cur()), 0);
      chk("abort_fc", int'(frame_count), 0);
      model_reset();
      @(negedge clk);
      chk("abort_hold", int'(cur()), 0);
      rst_n = 1'b1;
      single_frame("fresh", 16'd1);

      // Frame counter wrap.
      clr_counts();
      en   = 1'b0;
      rdy  = 1'b0;
      tick = 1'b0;
      force dut.r_frame_cnt = 16'hFFFF;
      m_fc = 16'hFFFF;
      step();
      release dut.r_frame_cnt;
      step();
      chk("wrap_preset", int'(frame_count), 16'hFFFF);
      en   = 1'b1;
      rdy  = 1'b1;
      tick = 1'b1;
      step();
      en  = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 50; i++) step();
      chk("wrap_n_done", n_done, 1);
      chk("wrap_fc", int'(frame_count), 0);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
